// File: rtl/xpe_pkg.sv
// Shared constants and helpers for the XNOR-popcount PE datapath.
// Mask generation here is reused by the packer and the PE array.
package xpe_pkg;

  localparam int XPE_WORD_SIZE = 64;
  localparam int XPE_MASK_MAX  = 256;

  // n low ones, saturated at ws positions
  function automatic logic [XPE_MASK_MAX-1:0] xpe_mask_f(
    input int unsigned n,
    input int unsigned ws
  );
    logic [XPE_MASK_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < XPE_MASK_MAX; i++) begin
      m[i] = (i < n) && (i < ws);
    end
    return m;
  endfunction

endpackage

// File: rtl/xpe_binarizer.sv
// Signed threshold compare: one activation becomes one packed bit.
// A 1 encodes +1 in the XNOR domain.
module xpe_binarizer #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] thr_i,
  output logic              bit_o
);

  // bit is set when the activation reaches the threshold
  always_comb begin
    bit_o = $signed(data_i) >= $signed(thr_i);
  end

endmodule

// File: rtl/xpe_act_packer.sv
// Streaming binarizer and LSB-first bit packer feeding the PE array.
// Emits {word, mask} per full word or at vector end.
module xpe_act_packer
  import xpe_pkg::*;
#(
  parameter int WORD_SIZE = XPE_WORD_SIZE,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    thr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_word,
  output logic [WORD_SIZE-1:0] out_mask,
  output logic                 out_last,
  output logic [IDX_W-1:0]     out_word_idx
);

  localparam int PW = $clog2(WORD_SIZE);
  localparam logic [PW-1:0] LAST_POS = PW'(WORD_SIZE - 1);

  logic [PW-1:0]        idx_q, idx_d;
  logic [WORD_SIZE-1:0] asm_q, asm_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic [WORD_SIZE-1:0] mask_q, mask_d;
  logic                 last_q, last_d;
  logic                 vld_q, vld_d;
  logic [IDX_W-1:0]     widx_q, widx_d;

  logic                 bit_w;
  logic                 acc;
  logic                 cmpl;
  logic                 xfer;
  logic [WORD_SIZE-1:0] asm_ins;
  logic [WORD_SIZE-1:0] fill;

  xpe_binarizer #(
    .DATA_W (DATA_W)
  ) u_bin (
    .data_i (in_data),
    .thr_i  (thr),
    .bit_o  (bit_w)
  );

  assign in_ready = !vld_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign cmpl     = acc && ((idx_q == LAST_POS) || in_last);
  assign xfer     = vld_q && out_ready;

  // assembly bits with the incoming bit placed, and populated-position mask
  always_comb begin
    asm_ins        = asm_q;
    asm_ins[idx_q] = bit_w;
    fill = WORD_SIZE'(xpe_mask_f(32'(idx_q) + 32'd1, WORD_SIZE));
  end

  // next-state for assembly, output register and word index
  always_comb begin
    idx_d  = idx_q;
    asm_d  = asm_q;
    word_d = word_q;
    mask_d = mask_q;
    last_d = last_q;
    vld_d  = vld_q;
    widx_d = widx_q;
    if (xfer) begin
      vld_d  = 1'b0;
      widx_d = last_q ? '0 : widx_q + IDX_W'(1);
    end
    if (cmpl) begin
      idx_d  = '0;
      asm_d  = '0;
      word_d = asm_ins & fill;
      mask_d = fill;
      last_d = in_last;
      vld_d  = 1'b1;
    end else if (acc) begin
      idx_d  = idx_q + PW'(1);
      asm_d  = asm_ins;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      asm_q  <= '0;
      word_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
      widx_q <= '0;
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      word_q <= word_d;
      mask_q <= mask_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      widx_q <= widx_d;
    end
  end

  assign out_valid    = vld_q;
  assign out_word     = word_q;
  assign out_mask     = mask_q;
  assign out_last     = last_q;
  assign out_word_idx = widx_q;

endmodule

// File: tb/tb_xpe_act_packer.sv
// Directed bench for xpe_act_packer at WORD_SIZE=8.
// Table-driven vectors plus hand sequences for stalls and reset.
module tb_xpe_act_packer;

  localparam int WS = 8;
  localparam int DW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] thr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WS-1:0] out_word;
  logic [WS-1:0] out_mask;
  logic          out_last;
  logic [IW-1:0] out_word_idx;

  xpe_act_packer #(
    .WORD_SIZE (WS),
    .DATA_W    (DW),
    .IDX_W     (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .thr          (thr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_mask     (out_mask),
    .out_last     (out_last),
    .out_word_idx (out_word_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   thr;
    int   data;
    logic last;
  } elem_t;

  typedef struct {
    logic [WS-1:0] word;
    logic [WS-1:0] mask;
    logic          last;
    logic [IW-1:0] idx;
  } exp_t;

  typedef struct {
    logic [WS-1:0] word;
    logic [WS-1:0] mask;
    logic          last;
    logic [IW-1:0] idx;
    int            cyc;
  } obs_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  obs_t oq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      oq.push_back('{out_word, out_mask, out_last, out_word_idx, cyc});
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic l, output int stalls);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = l;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    stalls   = t;
  endtask

  task automatic chk_word(input string nm, input obs_t o, input exp_t e);
    chk({nm, "_word"}, o.word, e.word);
    chk({nm, "_mask"}, o.mask, e.mask);
    chk({nm, "_last"}, o.last, e.last);
    chk({nm, "_idx"},  o.idx,  e.idx);
  endtask

  elem_t vt[$];
  exp_t  et[$];

  initial begin
    int st;
    int tot;
    int d1[8];
    int d3[3];
    int dc;
    int dr[8];
    obs_t o;

    d1 = '{5, -1, 0, -7, 3, -2, 1, -128};
    for (int i = 0; i < 8; i++) vt.push_back('{0, d1[i], i == 7});
    for (int i = 0; i < 11; i++) vt.push_back('{0, i + 1, i == 10});
    d3 = '{10, 9, 11};
    for (int i = 0; i < 3; i++) vt.push_back('{10, d3[i], i == 2});
    et.push_back('{8'h55, 8'hFF, 1'b1, 16'd0});
    et.push_back('{8'hFF, 8'hFF, 1'b0, 16'd0});
    et.push_back('{8'h07, 8'h07, 1'b1, 16'd1});
    et.push_back('{8'h05, 8'h07, 1'b1, 16'd0});

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_last", out_last, 0);
    chk("rst_widx", out_word_idx, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      thr = DW'(vt[i].thr);
      if (i == 7) chk("lat_pre", out_valid, 0);
      send(vt[i].data, vt[i].last, st);
      if (vt[i].last) chk($sformatf("lat_%0d", i), out_valid, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("tab_count", oq.size(), et.size());
    for (int i = 0; i < et.size() && i < oq.size(); i++)
      chk_word($sformatf("tab%0d", i), oq[i], et[i]);

    oq.delete();
    thr = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send((i % 2) ? 1 : -1, i == 7, st);
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = DW'(5);
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_rdy%0d", c), in_ready, 0);
      chk($sformatf("bp_word%0d", c), out_word, 8'hAA);
      chk($sformatf("bp_mask%0d", c), out_mask, 8'hFF);
      chk($sformatf("bp_last%0d", c), out_last, 1);
      chk($sformatf("bp_widx%0d", c), out_word_idx, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_word", out_word, 8'h01);
    chk("bp_next_mask", out_mask, 8'h01);
    chk("bp_next_widx", out_word_idx, 0);
    @(posedge clk);
    #1;
    chk("bp_count", oq.size(), 2);
    if (oq.size() == 2) begin
      chk_word("bp0", oq[0], '{8'hAA, 8'hFF, 1'b1, 16'd0});
      chk_word("bp1", oq[1], '{8'h01, 8'h01, 1'b1, 16'd0});
    end

    oq.delete();
    tot = 0;
    for (int k = 0; k < 24; k++) begin
      dc = (k % 3 == 0) ? 1 : -1;
      send(dc, k == 23, st);
      tot += st;
    end
    chk("cont_stalls", tot, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("cont_count", oq.size(), 3);
    if (oq.size() == 3) begin
      chk_word("cont0", oq[0], '{8'h49, 8'hFF, 1'b0, 16'd0});
      chk_word("cont1", oq[1], '{8'h92, 8'hFF, 1'b0, 16'd1});
      chk_word("cont2", oq[2], '{8'h24, 8'hFF, 1'b1, 16'd2});
      chk("cont_gap01", oq[1].cyc - oq[0].cyc, 8);
      chk("cont_gap12", oq[2].cyc - oq[1].cyc, 8);
    end

    oq.delete();
    for (int i = 0; i < 3; i++) send(7, 1'b0, st);
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_widx", out_word_idx, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_nout", oq.size(), 0);
    dr = '{3, -3, -3, 3, 3, -3, -3, 3};
    for (int i = 0; i < 8; i++) send(dr[i], i == 7, st);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_count", oq.size(), 1);
    if (oq.size() == 1) begin
      o = oq[0];
      chk_word("mrst", o, '{8'h99, 8'hFF, 1'b1, 16'd0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xpe_act_packer.md
# xpe_act_packer

Streaming binarizer and bit packer that produces the packed `{word, mask}` operands consumed by the XNOR-popcount PE array. It accepts one signed multi-bit activation per cycle over a valid/ready handshake and compares it against a programmable threshold to form one bit. Bits are packed LSB-first into WORD_SIZE-bit words. A word is emitted when it is full or when the vector ends, with a valid mask covering the populated positions so partial tail words count correctly downstream.

## Interface
- `WORD_SIZE`, 64: packed word width; must match the PE `WORD_SIZE`; power of two, ≥2.
- `DATA_W`, 8: signed activation width.
- `IDX_W`, 16: width of the per-vector word index counter.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `thr`  in  DATA_W  signed threshold; must be held stable while a vector is in flight.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an element this cycle.
- `in_data`  in  DATA_W  signed activation.
- `in_last`  in  1  final element of the current vector.
- `out_valid`  out  1  packed word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_word`  out  WORD_SIZE  packed bits; element k of the word sits at bit k.
- `out_mask`  out  WORD_SIZE  bit k is 1 iff position k holds a real element.
- `out_last`  out  1  word closes the vector.
- `out_word_idx`  out  IDX_W  index of `out_word` within its vector, starting at 0.

## Operation
- Binarize: bit = 1 iff `$signed(in_data) >= $signed(thr)`. The value +1 encodes as 1.
- Accept occurs when `in_valid && in_ready`. The bit is written into the assembly register at position `idx`; all other bits of the register are unchanged.
- A word completes when an element is accepted with `idx == WORD_SIZE-1` or with `in_last` = 1. On completion:
  - The assembly bits plus the new bit load into the output register.
  - Unpopulated positions are forced to 0 in both `out_word` and `out_mask`.
  - `out_mask = (1 << (idx+1)) - 1`, computed without overflow so that a full word gives all ones.
  - `out_last` = `in_last`.
  - `idx` returns to 0 and the assembly register clears.
- A non-completing accept increments `idx` only.
- `in_ready = !out_valid || out_ready`. This rule applies to every element, completing or not, so the output register can never be overwritten.
- Output handshake:
  - `out_valid` sets on completion.
  - `out_valid` clears on `out_valid && out_ready` unless a new completion occurs in the same cycle, in which case it stays 1 and the contents are replaced.
- `out_word_idx`:
  - Increments on each output transfer.
  - Resets to 0 on transfer of a word with `out_last` = 1.
  - Wraps modulo 2^IDX_W with no error flag.
- `in_last` with `idx == WORD_SIZE-1` produces exactly one word, with a full mask and `out_last` = 1. No empty trailing word is produced.
- A vector shorter than WORD_SIZE produces one partial word.

## Timing
- Reset values: `out_valid` = 0, `out_word` = 0, `out_mask` = 0, `out_last` = 0, `out_word_idx` = 0, `idx` = 0, assembly register = 0.
- Reset is asynchronous. Asserting `rst_n` mid-vector discards all partial state; the first accept after release goes to position 0.
- Latency: a completing element accepted at edge N has `out_valid` = 1 after edge N.
- Throughput: one element per cycle while `out_ready` is held high. A word every WORD_SIZE cycles leaves no bubbles.
- Under backpressure (`out_valid && !out_ready`): `in_ready` = 0, and `out_word`, `out_mask`, `out_last` and `out_word_idx` hold stable.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Structure
- Shared package `xpe_pkg`:
  - `XPE_WORD_SIZE` default constant.
  - `xpe_mask_f(n)` function, which returns n low ones and saturates at WORD_SIZE. The PE-side mask generation reuses it.
- Sub-module `xpe_binarizer`: combinational signed compare, with parameter `DATA_W`.
- Everything else (idx counter, assembly register, output register, word index) lives in the top module.

## Test plan
All scenarios use WORD_SIZE = 8 and DATA_W = 8.
- Reset: `thr` = 0, `out_ready` = 1. Stream 8 elements {5,-1,0,-7,3,-2,1,-128} with `in_last` on the 8th → `out_word` = 0x55, `out_mask` = 0xFF, `out_last` = 1, `out_word_idx` = 0, appearing one cycle after the last accept.
- Vector of 11 all-positive elements, `thr` = 0 → word 0: 0xFF/0xFF/last = 0/idx 0; word 1: 0x07/0x07/last = 1/idx 1. The next vector starts at idx 0.
- `thr` = 10, elements {10, 9, 11} with last → `out_word` = 0x05, `out_mask` = 0x07.
- Backpressure: hold `out_ready` = 0 after a word completes → `in_ready` = 0 and the output holds for 5 cycles. Release `out_ready` → transfer, and the next element is accepted in the same cycle.
- Continuous 24-element vector, `out_ready` = 1 → three words on consecutive 8-cycle boundaries, no `in_ready` deassertion, idx 0/1/2, last only on the third.
- Assert `rst_n` after 3 elements of a vector → no output. The following 8-element vector is packed from bit 0 with correct mask.
